// File: rtl/inst_prefetch_pkg.sv
// Shared types and default widths for the instruction prefetch stage.
package inst_prefetch_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    // One in-flight INST_MEM read, tracked until its data appears on inst.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic              epoch;
    } tag_t;

    // One queued instruction, tagged with the PC it was fetched from.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

endpackage

// File: rtl/inst_prefetch_if.sv
// Bus bundle for inst_prefetch: core control, INST_MEM port and the core-side
// instruction handshake.
//
// Handshake: inst_valid/inst_out/inst_pc describe the FIFO head. A transfer
// happens on a rising edge where inst_valid && inst_ready. inst_valid never
// depends on inst_ready. A redirect in the same cycle flushes the FIFO and
// overrides that transfer.
interface inst_prefetch_if;
    import inst_prefetch_pkg::*;

    logic              in_valid;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_cen;
    logic [DATA_W-1:0] inst;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    // The environment side: the core and the INST_MEM model.
    modport master (
        output in_valid, redirect_valid, redirect_pc, inst, inst_ready,
        input  inst_addr, inst_cen, inst_valid, inst_out, inst_pc
    );

    // The prefetch stage itself.
    modport slave (
        input  in_valid, redirect_valid, redirect_pc, inst, inst_ready,
        output inst_addr, inst_cen, inst_valid, inst_out, inst_pc
    );

endinterface

// File: rtl/inst_prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry synchronous FIFO of {pc, inst} entries.
// Flush has priority over push and pop. Push and pop may coincide, even when
// the FIFO is full. The head is read from registered storage, so nothing
// combinational runs from push_data to the head outputs.
module prefetch_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output entry_t           head
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_eff;
    logic             full;

    // A pop only counts when there is a head to take.
    always_comb begin
        head_valid = (count != '0);
        pop_eff    = pop && head_valid;
        full       = (count == CNT_W'(DEPTH));
        head       = mem[rd_ptr];
    end

    // Storage, pointers and occupancy. The pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop_eff})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The upstream credit check must make a push into a full FIFO without a
    // simultaneous pop impossible.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !pop_eff)
    );

endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch: instruction prefetch stage between INST_MEM and the core.
// It owns the fetch PC, issues reads under a credit limit, tracks the fixed
// MEM_LAT read latency with a tag shift register and queues the returned
// words in prefetch_fifo. A redirect flips the epoch, so words still in
// flight are dropped when they return.
//
// Optional feature macro: PREFETCH_STATS_EN adds saturating stall_cnt and
// flush_cnt outputs.
//
// The epoch is one bit. A stale word could only be accepted if two redirects
// landed while it was in flight, and with MEM_LAT=2 the second redirect
// flushes in the very cycle that word returns.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 2,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    inst_prefetch_if.slave bus
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              epoch_q;
    tag_t              tag_q [MEM_LAT];
    tag_t              last_tag;
    logic [CNT_W-1:0]  fifo_count;
    int                in_use;
    logic              credit_ok;
    logic              issue;
    logic              push;
    entry_t            push_data;
    logic              head_valid;
    entry_t            head;

    // Credit check and issue decision. Reads in flight count against the
    // FIFO depth, so every returning word is guaranteed a slot. Issue is held
    // off during reset so the chip enable is inactive at once.
    always_comb begin
        in_use = int'(fifo_count);
        for (int i = 0; i < MEM_LAT; i++) begin
            in_use = in_use + int'(tag_q[i].valid);
        end
        credit_ok = (in_use < DEPTH);
        issue     = rst_n && bus.in_valid && !bus.redirect_valid && credit_ok;
    end

    // INST_MEM port. The address holds its last issued value while idle.
    always_comb begin
        bus.inst_cen  = !issue;
        bus.inst_addr = issue ? pc_q : addr_q;
    end

    // Fetch PC, epoch and held address. A redirect reloads the PC and
    // starts a new epoch. Otherwise each issue advances the PC, which wraps
    // to zero at the top of the address space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            epoch_q <= 1'b0;
            addr_q  <= '0;
        end else if (bus.redirect_valid) begin
            pc_q    <= bus.redirect_pc;
            epoch_q <= ~epoch_q;
        end else if (issue) begin
            pc_q    <= pc_q + ADDR_W'(1);
            addr_q  <= pc_q;
        end
    end

    // Latency tracker: one stage per memory cycle. The last stage lines up
    // with the cycle in which inst carries the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_t'{valid: issue, pc: pc_q, epoch: epoch_q};
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Returning word: queue it only if it belongs to the current epoch.
    always_comb begin
        last_tag  = tag_q[MEM_LAT-1];
        push      = last_tag.valid && (last_tag.epoch == epoch_q);
        push_data = entry_t'{pc: last_tag.pc, inst: bus.inst};
    end

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.inst_ready),
        .flush     (bus.redirect_valid),
        .count     (fifo_count),
        .head_valid(head_valid),
        .head      (head)
    );

    // Core-side head outputs, taken straight from FIFO storage.
    always_comb begin
        bus.inst_valid = head_valid;
        bus.inst_out   = head.inst;
        bus.inst_pc    = head.pc;
    end

`ifdef PREFETCH_STATS_EN
    // Saturating counts of credit stalls and redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.in_valid && !bus.redirect_valid && !credit_ok &&
                stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (bus.redirect_valid && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
